data_island_packet_serializer: RTL

//  Serializes one HDMI data-island packet (24b header + four 56b subpackets from any InfoFrame/packet generator) over 32 pixel clocks.

---
 rtl/hdmi_packet_pkg.sv | 17 +
 rtl/bch_ecc_accumulator.sv | 36 +++
 rtl/data_island_packet_serializer.sv | 101 ++++++++++
 3 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared constants and the BCH step function used by the data-island serializer.
package hdmi_packet_pkg;

    localparam int unsigned PACKET_CYCLES    = 32;
    localparam int unsigned HEADER_DATA_BITS = 24;
    localparam int unsigned SUB_DATA_BITS    = 56;
    localparam logic [7:0]  BCH_POLY         = 8'h83;

    // One LSB-first LFSR step; poly is the reflected feedback mask.
    function automatic logic [7:0] bch_ecc_step(input logic [7:0] ecc, input logic din,
                                                input logic [7:0] poly);
        logic fb;
        fb = din ^ ecc[0];
        return {1'b0, ecc[7:1]} ^ ({8{fb}} & poly);
    endfunction

endpackage

// File: rtl/bch_ecc_accumulator.sv
// BCH parity accumulator: absorbs 1 or 2 data bits per cycle, bit 0 first.
module bch_ecc_accumulator
    import hdmi_packet_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter logic [7:0]  POLY           = 8'h83
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      clear_i,
    input  logic                      advance_i,
    input  logic [BITS_PER_CYCLE-1:0] bits_i,
    output logic [7:0]                ecc_o
);

    logic [7:0] ecc_d;

    // clear with advance starts a fresh codeword from the current bits.
    always_comb begin
        ecc_d = clear_i ? 8'h00 : ecc_o;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            ecc_d = bch_ecc_step(ecc_d, bits_i[i], POLY);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ecc_o <= 8'h00;
        end else if (advance_i) begin
            ecc_o <= ecc_d;
        end else if (clear_i) begin
            ecc_o <= 8'h00;
        end
    end

endmodule

// File: rtl/data_island_packet_serializer.sv
// Serializes one HDMI data-island packet (header + 4 subpackets + BCH parity) over 32 cycles,
// 9 bits per cycle toward the TERC4 encoders.
module data_island_packet_serializer #(
    parameter logic [7:0] BCH_POLY = 8'h83
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             enable,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [8:0]       packet_data,
    output logic             packet_start,
    output logic             packet_end,
    output logic             packet_aborted
);
    import hdmi_packet_pkg::*;

    logic [4:0]       cnt_q;
    logic [23:0]      hdr_q;
    logic [3:0][55:0] sub_q;

    logic             first;
    logic             clear;
    logic             hdr_phase;
    logic             sub_phase;
    logic [23:0]      hdr_cur;
    logic [3:0][55:0] sub_cur;
    logic             hdr_data;
    logic             hdr_bit;
    logic [7:0]       ecc_h;
    logic [3:0]       even_bits;
    logic [3:0]       odd_bits;
    logic [2:0]       par_idx;

    assign first     = (cnt_q == 5'd0);
    assign clear     = !enable || first;
    assign hdr_phase = (cnt_q < 5'(HEADER_DATA_BITS));
    assign sub_phase = (cnt_q < 5'(SUB_DATA_BITS / 2));
    // Cycle 0 must use the live inputs since the shadow only loads on that same edge.
    assign hdr_cur   = first ? header : hdr_q;
    assign sub_cur   = first ? sub : sub_q;
    assign hdr_data  = hdr_cur[cnt_q];
    assign hdr_bit   = hdr_phase ? hdr_data : ecc_h[cnt_q[2:0]];
    assign par_idx   = {cnt_q[1:0], 1'b0};

    bch_ecc_accumulator #(
        .BITS_PER_CYCLE(1),
        .POLY          (BCH_POLY)
    ) u_ecc_hdr (
        .clk_i    (clk_pixel),
        .reset_i  (reset),
        .clear_i  (clear),
        .advance_i(enable && hdr_phase),
        .bits_i   (hdr_data),
        .ecc_o    (ecc_h)
    );

    for (genvar k = 0; k < 4; k++) begin : g_sub
        logic [1:0] data_bits;
        logic [7:0] ecc_s;

        assign data_bits    = {sub_cur[k][{cnt_q, 1'b1}], sub_cur[k][{cnt_q, 1'b0}]};
        assign even_bits[k] = sub_phase ? data_bits[0] : ecc_s[par_idx];
        assign odd_bits[k]  = sub_phase ? data_bits[1] : ecc_s[par_idx + 3'd1];

        bch_ecc_accumulator #(
            .BITS_PER_CYCLE(2),
            .POLY          (BCH_POLY)
        ) u_ecc_sub (
            .clk_i    (clk_pixel),
            .reset_i  (reset),
            .clear_i  (clear),
            .advance_i(enable && sub_phase),
            .bits_i   (data_bits),
            .ecc_o    (ecc_s)
        );
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cnt_q          <= 5'd0;
            hdr_q          <= '0;
            sub_q          <= '0;
            packet_data    <= 9'd0;
            packet_start   <= 1'b0;
            packet_end     <= 1'b0;
            packet_aborted <= 1'b0;
        end else begin
            cnt_q <= enable ? cnt_q + 5'd1 : 5'd0;
            if (enable && first) begin
                hdr_q <= header;
                sub_q <= sub;
            end
            packet_data    <= enable ? {odd_bits, even_bits, hdr_bit} : 9'd0;
            packet_start   <= enable && first;
            packet_end     <= enable && (cnt_q == 5'(PACKET_CYCLES - 1));
            packet_aborted <= !enable && !first;
        end
    end

endmodule
